// File: rtl/pixel_stream_framer.sv
// Re-frames an end-of-frame-only pixel stream into an AXI4-Stream video stream
// (TUSER = start of frame, TLAST = end of line). Optional macro: FRAME_REPAIR_EN.
module pixel_stream_framer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  pixel_stream_TVALID,
  output logic                  pixel_stream_TREADY,
  input  logic [DATA_WIDTH-1:0] pixel_stream_TDATA,
  input  logic                  pixel_stream_TLAST,
  output logic                  video_stream_TVALID,
  input  logic                  video_stream_TREADY,
  output logic [DATA_WIDTH-1:0] video_stream_TDATA,
  output logic                  video_stream_TUSER,
  output logic                  video_stream_TLAST,
  output logic                  frame_done,
  output logic                  err_short,
  output logic                  err_long,
  output logic [15:0]           frame_count
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {PASS, PAD, DROP} state_t;

  state_t          state_reg, state_next;
  logic [XW-1:0]   x_reg;
  logic [YW-1:0]   y_reg;
  logic [EW-1:0]   skid_mem [0:1];
  logic            rd_ptr_reg, wr_ptr_reg;
  logic [1:0]      count_reg, count_next;
  logic            tready_reg, tready_next;
  logic [15:0]     frame_count_reg;

  logic                  accept, deq, enq;
  logic                  last_x, last_y, at_last;
  logic                  clear_pos, advance_pos;
  logic                  done_next, short_next, long_next;
  logic [DATA_WIDTH-1:0] wdata;
  logic [EW-1:0]         entry;

  assign accept  = pixel_stream_TVALID && tready_reg && !ap_rst;
  assign deq     = (count_reg != 2'd0) && video_stream_TREADY;
  assign last_x  = (x_reg == X_LAST);
  assign last_y  = (y_reg == Y_LAST);
  assign at_last = last_x && last_y;

  always_comb begin
    state_next  = state_reg;
    enq         = 1'b0;
    wdata       = pixel_stream_TDATA;
    clear_pos   = 1'b0;
    advance_pos = 1'b0;
    done_next   = 1'b0;
    short_next  = 1'b0;
    long_next   = 1'b0;
    case (state_reg)
      PASS: begin
        if (accept) begin
          enq = 1'b1;
          if (at_last) begin
            clear_pos = 1'b1;
            done_next = 1'b1;
            if (!pixel_stream_TLAST) begin
              long_next = 1'b1;
`ifdef FRAME_REPAIR_EN
              state_next = DROP;
`endif
            end
          end else if (pixel_stream_TLAST) begin
            short_next = 1'b1;
`ifdef FRAME_REPAIR_EN
            advance_pos = 1'b1;
            state_next  = PAD;
`else
            clear_pos = 1'b1;
            done_next = 1'b1;
`endif
          end else begin
            advance_pos = 1'b1;
          end
        end
      end
`ifdef FRAME_REPAIR_EN
      // Fill the rest of a short frame with black pixels.
      PAD: begin
        wdata = '0;
        if ((count_reg != 2'd2) && !ap_rst) begin
          enq = 1'b1;
          if (at_last) begin
            clear_pos  = 1'b1;
            done_next  = 1'b1;
            state_next = PASS;
          end else begin
            advance_pos = 1'b1;
          end
        end
      end
      DROP: begin
        if (accept && pixel_stream_TLAST) state_next = PASS;
      end
`endif
      default: state_next = PASS;
    endcase
  end

  assign entry      = {wdata, (x_reg == '0) && (y_reg == '0), last_x};
  assign count_next = count_reg + {1'b0, enq} - {1'b0, deq};

  // Input ready is registered, so it is computed from next-cycle occupancy.
  always_comb begin
    case (state_next)
      PASS:    tready_next = (count_next != 2'd2);
      DROP:    tready_next = 1'b1;
      default: tready_next = 1'b0;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg       <= PASS;
      x_reg           <= '0;
      y_reg           <= '0;
      skid_mem[0]     <= '0;
      skid_mem[1]     <= '0;
      rd_ptr_reg      <= 1'b0;
      wr_ptr_reg      <= 1'b0;
      count_reg       <= 2'd0;
      tready_reg      <= 1'b0;
      frame_count_reg <= 16'd0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      tready_reg <= tready_next;
      if (clear_pos) begin
        x_reg <= '0;
        y_reg <= '0;
      end else if (advance_pos) begin
        if (last_x) begin
          x_reg <= '0;
          y_reg <= last_y ? '0 : y_reg + 1'b1;
        end else begin
          x_reg <= x_reg + 1'b1;
        end
      end
      if (enq) begin
        skid_mem[wr_ptr_reg] <= entry;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (deq) rd_ptr_reg <= ~rd_ptr_reg;
      if (done_next) frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign pixel_stream_TREADY = tready_reg;
  assign video_stream_TVALID = (count_reg != 2'd0);
  assign {video_stream_TDATA, video_stream_TUSER, video_stream_TLAST} = skid_mem[rd_ptr_reg];
  assign frame_done  = done_next && !ap_rst;
  assign err_short   = short_next && !ap_rst;
  assign err_long    = long_next && !ap_rst;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Directed bench for pixel_stream_framer with a 4x2 geometry; works with or
// without FRAME_REPAIR_EN.
module tb_pixel_stream_framer;

  localparam int DW = 24;

  typedef struct {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
    int            c;
  } beat_t;

  logic          ap_clk, ap_rst;
  logic          pix_valid, pix_last;
  logic [DW-1:0] pix_data;
  logic          pixel_stream_TREADY;
  logic          video_stream_TVALID, out_ready;
  logic [DW-1:0] video_stream_TDATA;
  logic          video_stream_TUSER, video_stream_TLAST;
  logic          frame_done, err_short, err_long;
  logic [15:0]   frame_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cnt_done, cnt_es, cnt_el;
  int occ;
  bit rand_ready = 0;
  bit chk_occ = 0;
  bit stall_prev;
  beat_t held;
  beat_t outq[$];
  int acc_cyc[$];
  bit acc_done[$], acc_es[$], acc_el[$];

  pixel_stream_framer #(.H_ACTIVE(4), .V_ACTIVE(2), .DATA_WIDTH(DW)) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .pixel_stream_TVALID(pix_valid),
    .pixel_stream_TREADY(pixel_stream_TREADY),
    .pixel_stream_TDATA(pix_data),
    .pixel_stream_TLAST(pix_last),
    .video_stream_TVALID(video_stream_TVALID),
    .video_stream_TREADY(out_ready),
    .video_stream_TDATA(video_stream_TDATA),
    .video_stream_TUSER(video_stream_TUSER),
    .video_stream_TLAST(video_stream_TLAST),
    .frame_done(frame_done),
    .err_short(err_short),
    .err_long(err_long),
    .frame_count(frame_count)
  );

  initial begin
    ap_clk = 0;
    forever #5 ap_clk = ~ap_clk;
  end

  always @(posedge ap_clk) begin
    cyc <= cyc + 1;
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  // Output monitor: collects beats, counts pulses, checks AXIS hold and skid occupancy.
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      occ = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!video_stream_TVALID || video_stream_TDATA !== held.d ||
            video_stream_TUSER !== held.u || video_stream_TLAST !== held.l) begin
          failures++;
          $display("FAIL hold_stable got v=%0b d=%0d u=%0b l=%0b want v=1 d=%0d u=%0b l=%0b",
                   video_stream_TVALID, video_stream_TDATA, video_stream_TUSER,
                   video_stream_TLAST, held.d, held.u, held.l);
        end
      end
      if (video_stream_TVALID && out_ready)
        outq.push_back('{d: video_stream_TDATA, u: video_stream_TUSER, l: video_stream_TLAST, c: cyc});
      stall_prev = video_stream_TVALID && !out_ready;
      held = '{d: video_stream_TDATA, u: video_stream_TUSER, l: video_stream_TLAST, c: cyc};
      cnt_done += int'(frame_done);
      cnt_es += int'(err_short);
      cnt_el += int'(err_long);
      if (err_short || err_long) begin
        checks++;
        if (err_short && err_long) begin
          failures++;
          $display("FAIL err_exclusive got short=1 long=1 want at most one");
        end
      end
      if (chk_occ && !pixel_stream_TREADY) begin
        checks++;
        if (occ != 2) begin
          failures++;
          $display("FAIL tready_low got occupancy=%0d want 2", occ);
        end
      end
      occ = occ + int'(pix_valid && pixel_stream_TREADY) - int'(video_stream_TVALID && out_ready);
    end
  end

  function automatic beat_t get_beat(input int i);
    beat_t b;
    b = '{d: 'x, u: 1'bx, l: 1'bx, c: -1};
    if (i < outq.size()) b = outq[i];
    return b;
  endfunction

  task automatic do_reset();
    ap_rst = 1;
    pix_valid = 0;
    pix_last = 0;
    pix_data = '0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 0;
    @(posedge ap_clk);
    #1;
    outq.delete();
    acc_cyc.delete();
    acc_done.delete();
    acc_es.delete();
    acc_el.delete();
    cnt_done = 0;
    cnt_es = 0;
    cnt_el = 0;
  endtask

  // Sends n beats first..first+n-1, TLAST every 'period' beats (0 = never).
  task automatic send_frame(input int n, input int first, input int period);
    int waited;
    bit got;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      got = 0;
      pix_valid = 1;
      pix_data = DW'(first + i);
      pix_last = (period > 0) && (((i + 1) % period) == 0);
      while (!got && waited < 200) begin
        @(negedge ap_clk);
        if (pixel_stream_TREADY) begin
          got = 1;
          acc_cyc.push_back(cyc);
          acc_done.push_back(frame_done);
          acc_es.push_back(err_short);
          acc_el.push_back(err_long);
        end
        @(posedge ap_clk);
        #1;
        waited++;
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL send_timeout got no accept of pixel %0d want accept", first + i);
      end
    end
    pix_valid = 0;
    pix_last = 0;
  endtask

  task automatic wait_out(input int n);
    int waited;
    waited = 0;
    while (outq.size() < n && waited < 400) begin
      @(negedge ap_clk);
      waited++;
    end
    repeat (4) @(negedge ap_clk);
    checks++;
    if (outq.size() != n) begin
      failures++;
      $display("FAIL out_count got %0d want %0d", outq.size(), n);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1;
    pix_valid = 0;
    pix_last = 0;
    pix_data = '0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (pixel_stream_TREADY !== 1'b0 || video_stream_TVALID !== 1'b0 || video_stream_TDATA !== '0 ||
        video_stream_TUSER !== 1'b0 || video_stream_TLAST !== 1'b0 || frame_done !== 1'b0 ||
        err_short !== 1'b0 || err_long !== 1'b0 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_values got rdy=%0b v=%0b d=%0d u=%0b l=%0b fd=%0b es=%0b el=%0b fc=%0d want all 0",
               pixel_stream_TREADY, video_stream_TVALID, video_stream_TDATA, video_stream_TUSER,
               video_stream_TLAST, frame_done, err_short, err_long, frame_count);
    end
    @(posedge ap_clk);
    #1 ap_rst = 0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (pixel_stream_TREADY !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got %0b want 1", pixel_stream_TREADY);
    end
  endtask

  task automatic test_normal();
    beat_t b;
    do_reset();
    send_frame(8, 1, 8);
    wait_out(8);
    for (int i = 0; i < 8; i++) begin
      b = get_beat(i);
      checks++;
      if (b.d !== DW'(i + 1) || b.u !== (i == 0) || b.l !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL normal_beat%0d got d=%0d u=%0b l=%0b want d=%0d u=%0b l=%0b",
                 i, b.d, b.u, b.l, i + 1, i == 0, i % 4 == 3);
      end
    end
    b = get_beat(0);
    checks++;
    if (acc_cyc.size() == 0 || b.c - acc_cyc[0] != 1) begin
      failures++;
      $display("FAIL normal_latency got out_cycle=%0d want accept_cycle+1", b.c);
    end
    checks++;
    if (cnt_done != 1 || frame_count !== 16'd1 || cnt_es != 0 || cnt_el != 0) begin
      failures++;
      $display("FAIL normal_counts got done=%0d fc=%0d es=%0d el=%0d want 1 1 0 0",
               cnt_done, frame_count, cnt_es, cnt_el);
    end
  endtask

  task automatic test_backpressure();
    beat_t b;
    do_reset();
    rand_ready = 1;
    chk_occ = 1;
    send_frame(16, 31, 8);
    wait_out(16);
    rand_ready = 0;
    chk_occ = 0;
    for (int i = 0; i < 16; i++) begin
      b = get_beat(i);
      checks++;
      if (b.d !== DW'(31 + i) || b.u !== (i % 8 == 0) || b.l !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL bp_beat%0d got d=%0d u=%0b l=%0b want d=%0d u=%0b l=%0b",
                 i, b.d, b.u, b.l, 31 + i, i % 8 == 0, i % 4 == 3);
      end
    end
    checks++;
    if (frame_count !== 16'd2) begin
      failures++;
      $display("FAIL bp_frame_count got %0d want 2", frame_count);
    end
  endtask

  task automatic test_short();
    beat_t b;
    int base;
    logic [DW-1:0] ed;
    do_reset();
    send_frame(5, 1, 5);
    send_frame(8, 11, 8);
`ifdef FRAME_REPAIR_EN
    base = 8;
`else
    base = 5;
`endif
    wait_out(base + 8);
    for (int i = 0; i < base; i++) begin
      b = get_beat(i);
      ed = (i < 5) ? DW'(i + 1) : '0;
      checks++;
      if (b.d !== ed || b.u !== (i == 0) || b.l !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL short_beat%0d got d=%0d u=%0b l=%0b want d=%0d u=%0b l=%0b",
                 i, b.d, b.u, b.l, ed, i == 0, i % 4 == 3);
      end
    end
    b = get_beat(base);
    checks++;
    if (b.d !== DW'(11) || b.u !== 1'b1) begin
      failures++;
      $display("FAIL short_next_sof got d=%0d u=%0b want d=11 u=1", b.d, b.u);
    end
    checks++;
    if (acc_es.size() < 5 || acc_es[4] !== 1'b1 || cnt_es != 1) begin
      failures++;
      $display("FAIL short_err got count=%0d want 1 at accept of pixel 5", cnt_es);
    end
    checks++;
`ifdef FRAME_REPAIR_EN
    if (acc_done.size() < 5 || acc_done[4] !== 1'b0 || cnt_done != 2 || frame_count !== 16'd2) begin
`else
    if (acc_done.size() < 5 || acc_done[4] !== 1'b1 || cnt_done != 2 || frame_count !== 16'd2) begin
`endif
      failures++;
      $display("FAIL short_done got done=%0d fc=%0d want 2 2", cnt_done, frame_count);
    end
  endtask

  task automatic test_long();
    beat_t b;
    int base;
    do_reset();
    send_frame(10, 1, 10);
    send_frame(8, 11, 8);
`ifdef FRAME_REPAIR_EN
    base = 8;
`else
    base = 10;
`endif
    wait_out(base + 8);
    for (int i = 0; i < base; i++) begin
      b = get_beat(i);
      checks++;
      if (b.d !== DW'(i + 1) || b.u !== (i % 8 == 0) || b.l !== (i == 3 || i == 7)) begin
        failures++;
        $display("FAIL long_beat%0d got d=%0d u=%0b l=%0b want d=%0d u=%0b l=%0b",
                 i, b.d, b.u, b.l, i + 1, i % 8 == 0, i == 3 || i == 7);
      end
    end
    b = get_beat(base);
    checks++;
    if (b.d !== DW'(11) || b.u !== 1'b1) begin
      failures++;
      $display("FAIL long_next_sof got d=%0d u=%0b want d=11 u=1", b.d, b.u);
    end
    checks++;
    if (acc_el.size() < 8 || acc_el[7] !== 1'b1 || cnt_el != 1) begin
      failures++;
      $display("FAIL long_err got count=%0d want 1 at accept of pixel 8", cnt_el);
    end
    checks++;
`ifdef FRAME_REPAIR_EN
    if (cnt_es != 0 || cnt_done != 2) begin
      failures++;
      $display("FAIL long_counts got es=%0d done=%0d want 0 2", cnt_es, cnt_done);
    end
`else
    if (cnt_es != 1 || cnt_done != 3) begin
      failures++;
      $display("FAIL long_counts got es=%0d done=%0d want 1 3", cnt_es, cnt_done);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    beat_t b;
    do_reset();
    send_frame(8, 1, 8);
    send_frame(3, 11, 0);
    ap_rst = 1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (pixel_stream_TREADY !== 1'b0 || video_stream_TVALID !== 1'b0 || video_stream_TDATA !== '0 ||
        video_stream_TUSER !== 1'b0 || video_stream_TLAST !== 1'b0 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL midrst_values got rdy=%0b v=%0b d=%0d u=%0b l=%0b fc=%0d want all 0",
               pixel_stream_TREADY, video_stream_TVALID, video_stream_TDATA, video_stream_TUSER,
               video_stream_TLAST, frame_count);
    end
    @(posedge ap_clk);
    #1 ap_rst = 0;
    @(posedge ap_clk);
    #1;
    outq.delete();
    cnt_done = 0;
    send_frame(8, 21, 8);
    wait_out(8);
    b = get_beat(0);
    checks++;
    if (b.d !== DW'(21) || b.u !== 1'b1) begin
      failures++;
      $display("FAIL midrst_sof got d=%0d u=%0b want d=21 u=1", b.d, b.u);
    end
    checks++;
    if (frame_count !== 16'd1) begin
      failures++;
      $display("FAIL midrst_frame_count got %0d want 1", frame_count);
    end
  endtask

  task automatic test_back_to_back();
    beat_t b, b0;
    do_reset();
    send_frame(24, 1, 8);
    wait_out(24);
    b0 = get_beat(0);
    for (int i = 0; i < 24; i++) begin
      b = get_beat(i);
      checks++;
      if (b.d !== DW'(i + 1) || b.u !== (i % 8 == 0) || b.l !== (i % 4 == 3) || b.c != b0.c + i) begin
        failures++;
        $display("FAIL stream_beat%0d got d=%0d u=%0b l=%0b cyc=%0d want d=%0d u=%0b l=%0b cyc=%0d",
                 i, b.d, b.u, b.l, b.c, i + 1, i % 8 == 0, i % 4 == 3, b0.c + i);
      end
    end
    checks++;
    if (frame_count !== 16'd3 || cnt_done != 3 || cnt_es != 0 || cnt_el != 0) begin
      failures++;
      $display("FAIL stream_counts got fc=%0d done=%0d es=%0d el=%0d want 3 3 0 0",
               frame_count, cnt_done, cnt_es, cnt_el);
    end
  endtask

  initial begin
    out_ready = 1;
    test_reset();
    test_normal();
    test_backpressure();
    test_short();
    test_long();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
